// File: rtl/period_rate_pkg.sv
// rtl/period_rate_pkg.sv - shared FSM type and constants for the period rate meter
package period_rate_pkg;

    // Measurement FSM: IDLE waits for enable, MEASURE runs back-to-back windows.
    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_MEASURE = 1'b1
    } state_t;

    localparam int DEFAULT_WINDOW_CYCLES = 1024;

    // Zero-window counter width; wide enough for the largest stall threshold (15).
    localparam int ZERO_CNT_W = 4;

endpackage

// File: rtl/period_rate_window_cnt.sv
// rtl/period_rate_window_cnt.sv - measurement window counter with terminal-count flag
//
// Ports:
//   clk     - clock
//   reset   - synchronous active-high reset, count returns to 0
//   restart - synchronous restart, count returns to 0
//   run     - advance the count this cycle (wraps to 0 after the last cycle)
//   tc      - count is at WINDOW_CYCLES-1, the last cycle of the window
module period_rate_window_cnt
    import period_rate_pkg::*;
#(
    parameter int WINDOW_CYCLES = DEFAULT_WINDOW_CYCLES
) (
    input  logic clk,
    input  logic reset,
    input  logic restart,
    input  logic run,
    output logic tc
);

    localparam int CNT_W = $clog2(WINDOW_CYCLES);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WINDOW_CYCLES - 1);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk) begin
        if (reset || restart) begin
            count <= '0;
        end else if (run) begin
            count <= tc ? '0 : count + CNT_W'(1);
        end
    end

    assign tc = (count == LAST);

endmodule

// File: rtl/period_rate_meter.sv
// rtl/period_rate_meter.sv - counter-delta rate meter over fixed windows with stall detect
//
// Optional feature: define PERIOD_RATE_MINMAX_EN to add min_rate/max_rate tracking.
//
// Ports:
//   clk        - sole clock
//   reset      - synchronous active-high reset, priority over clear and enable
//   in_cnt     - free-running counter snapshot, already in the clk domain
//   enable     - level-sensitive measurement enable
//   clear      - single-cycle restart of measurement and statistics
//   rate       - in_cnt delta over the last completed window
//   rate_valid - one-cycle pulse when rate is updated
//   stalled    - in_cnt unchanged for STALL_WINDOWS consecutive windows
//   min_rate   - smallest rate since reset/clear (PERIOD_RATE_MINMAX_EN only)
//   max_rate   - largest rate since reset/clear (PERIOD_RATE_MINMAX_EN only)
module period_rate_meter
    import period_rate_pkg::*;
#(
    parameter int BUS_SIZE      = 8,
    parameter int WINDOW_CYCLES = DEFAULT_WINDOW_CYCLES,
    parameter int STALL_WINDOWS = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [BUS_SIZE-1:0] in_cnt,
    input  logic                enable,
    input  logic                clear,
    output logic [BUS_SIZE-1:0] rate,
    output logic                rate_valid,
    output logic                stalled
`ifdef PERIOD_RATE_MINMAX_EN
    ,
    output logic [BUS_SIZE-1:0] min_rate,
    output logic [BUS_SIZE-1:0] max_rate
`endif
);

    localparam logic [ZERO_CNT_W-1:0] STALL_LIMIT = ZERO_CNT_W'(STALL_WINDOWS);

    state_t state, state_next;
    logic   capture;
    logic   measure_tc;
    logic   win_restart;
    logic   win_run;
    logic   tc;

    logic [BUS_SIZE-1:0]   prev;
    logic [BUS_SIZE-1:0]   delta;
    logic [ZERO_CNT_W-1:0] zero_cnt;
    logic [ZERO_CNT_W-1:0] zero_next;

    period_rate_window_cnt #(
        .WINDOW_CYCLES(WINDOW_CYCLES)
    ) u_window_cnt (
        .clk    (clk),
        .reset  (reset),
        .restart(win_restart),
        .run    (win_run),
        .tc     (tc)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // clear overrides everything, including a coinciding terminal count.
    always_comb begin
        state_next  = state;
        capture     = 1'b0;
        measure_tc  = 1'b0;
        win_restart = 1'b0;
        win_run     = 1'b0;
        if (clear) begin
            state_next  = enable ? ST_MEASURE : ST_IDLE;
            capture     = enable;
            win_restart = 1'b1;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (enable) begin
                        state_next  = ST_MEASURE;
                        capture     = 1'b1;
                        win_restart = 1'b1;
                    end
                end
                ST_MEASURE: begin
                    if (!enable) begin
                        // Partial window is discarded; rate and stalled hold.
                        state_next  = ST_IDLE;
                        win_restart = 1'b1;
                    end else begin
                        win_run    = 1'b1;
                        measure_tc = tc;
                    end
                end
                default: state_next = ST_IDLE;
            endcase
        end
    end

    // Modulo subtraction absorbs a single upstream counter wrap per window.
    assign delta = in_cnt - prev;

    always_comb begin
        zero_next = zero_cnt;
        if (delta != '0) begin
            zero_next = '0;
        end else if (zero_cnt != STALL_LIMIT) begin
            zero_next = zero_cnt + ZERO_CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            prev       <= '0;
            rate       <= '0;
            rate_valid <= 1'b0;
            stalled    <= 1'b0;
            zero_cnt   <= '0;
        end else begin
            rate_valid <= 1'b0;
            if (capture || measure_tc) begin
                prev <= in_cnt;
            end
            if (clear) begin
                rate     <= '0;
                stalled  <= 1'b0;
                zero_cnt <= '0;
            end else if (measure_tc) begin
                rate       <= delta;
                rate_valid <= 1'b1;
                zero_cnt   <= zero_next;
                stalled    <= (zero_next == STALL_LIMIT);
            end
        end
    end

`ifdef PERIOD_RATE_MINMAX_EN
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            min_rate <= '1;
            max_rate <= '0;
        end else if (measure_tc) begin
            if (delta < min_rate) min_rate <= delta;
            if (delta > max_rate) max_rate <= delta;
        end
    end
`endif

endmodule

// File: tb/tb_period_rate_meter.sv
// tb/tb_period_rate_meter.sv - self-checking bench for period_rate_meter
module tb_period_rate_meter;

    localparam int BUS   = 8;
    localparam int WIN   = 16;
    localparam int STALL = 2;

    logic           clk = 1'b0;
    logic           reset;
    logic [BUS-1:0] in_cnt;
    logic           enable;
    logic           clear;
    logic [BUS-1:0] rate;
    logic           rate_valid;
    logic           stalled;
`ifdef PERIOD_RATE_MINMAX_EN
    logic [BUS-1:0] min_rate;
    logic [BUS-1:0] max_rate;
`endif

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    period_rate_meter #(
        .BUS_SIZE     (BUS),
        .WINDOW_CYCLES(WIN),
        .STALL_WINDOWS(STALL)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_cnt    (in_cnt),
        .enable    (enable),
        .clear     (clear),
        .rate      (rate),
        .rate_valid(rate_valid),
        .stalled   (stalled)
`ifdef PERIOD_RATE_MINMAX_EN
        ,
        .min_rate  (min_rate),
        .max_rate  (max_rate)
`endif
    );

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t",
                     name, act, act, exp, exp, $time);
        end
    endtask

    // Reference model: a window closes on the WIN-th edge after the counter
    // was captured; rate is the modulo delta since that capture.
    bit model_live = 0;
    bit active;
    int age;
    int m_prev, m_rate, m_zeros, m_min, m_max;
    bit m_valid, m_stalled;

    always @(posedge clk) begin
        int d;
        model_live = 1;
        if (reset) begin
            active = 0; age = 0; m_prev = 0; m_rate = 0; m_valid = 0;
            m_stalled = 0; m_zeros = 0; m_min = 255; m_max = 0;
        end else begin
            m_valid = 0;
            if (clear) begin
                m_rate = 0; m_stalled = 0; m_zeros = 0; m_min = 255; m_max = 0;
                active = enable; age = 0;
                if (enable) m_prev = int'(in_cnt);
            end else if (!active) begin
                if (enable) begin
                    active = 1; age = 0; m_prev = int'(in_cnt);
                end
            end else if (!enable) begin
                active = 0; age = 0;
            end else begin
                age++;
                if (age == WIN) begin
                    d = (int'(in_cnt) - m_prev) & 255;
                    m_rate = d; m_valid = 1; m_prev = int'(in_cnt); age = 0;
                    m_zeros = (d == 0) ? ((m_zeros + 1 > STALL) ? STALL : m_zeros + 1) : 0;
                    m_stalled = (m_zeros == STALL);
                    if (d < m_min) m_min = d;
                    if (d > m_max) m_max = d;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (model_live) begin
            chk("model rate_valid", int'(rate_valid), int'(m_valid));
            chk("model rate", int'(rate), m_rate);
            chk("model stalled", int'(stalled), int'(m_stalled));
`ifdef PERIOD_RATE_MINMAX_EN
            chk("model min_rate", int'(min_rate), m_min);
            chk("model max_rate", int'(max_rate), m_max);
`endif
        end
    end

    // Adds inc to in_cnt before every edge; returns after the negedge that
    // sees rate_valid, with n = number of edges waited.
    task automatic wait_pulse(input int inc, output int n);
        bit got = 0;
        n = 0;
        for (int k = 0; k < 40 && !got; k++) begin
            in_cnt = in_cnt + BUS'(inc);
            @(negedge clk);
            n++;
            if (rate_valid) got = 1;
        end
        if (!got) chk("pulse timeout", 0, 1);
    endtask

    initial begin
        int n;
        reset = 1'b1; enable = 1'b0; clear = 1'b0; in_cnt = '0;
        repeat (3) @(negedge clk);
        chk("reset rate", int'(rate), 0);
        chk("reset rate_valid", int'(rate_valid), 0);
        chk("reset stalled", int'(stalled), 0);
`ifdef PERIOD_RATE_MINMAX_EN
        chk("reset min_rate", int'(min_rate), 255);
        chk("reset max_rate", int'(max_rate), 0);
`endif
        reset = 1'b0;
        in_cnt = 8'd5;
        @(negedge clk);

        // +3 per cycle, enable held
        enable = 1'b1;
        wait_pulse(3, n);
        chk("inc3 first latency", n, WIN + 1);
        chk("inc3 rate", int'(rate), 48);
        chk("inc3 stalled", int'(stalled), 0);
        wait_pulse(3, n);
        chk("inc3 period", n, WIN);
        chk("inc3 rate 2", int'(rate), 48);

        // enable dropped at win_cnt=7, re-raised 5 cycles later
        for (int i = 0; i < 7; i++) begin
            in_cnt = in_cnt + 8'd3;
            @(negedge clk);
        end
        enable = 1'b0;
        for (int i = 0; i < 5; i++) begin
            in_cnt = in_cnt + 8'd3;
            @(negedge clk);
            chk("drop no pulse", int'(rate_valid), 0);
            chk("drop rate held", int'(rate), 48);
        end
        enable = 1'b1;
        wait_pulse(3, n);
        chk("reenable latency", n, WIN + 1);
        chk("reenable rate", int'(rate), 48);

        // wrap: prev=0xF0, in_cnt=0x20 at terminal count
        enable = 1'b0;
        repeat (2) @(negedge clk);
        in_cnt = 8'hF0;
        enable = 1'b1;
        @(negedge clk);
        in_cnt = 8'h20;
        wait_pulse(0, n);
        chk("wrap latency", n, WIN);
        chk("wrap rate", int'(rate), 8'h30);
        chk("wrap stalled", int'(stalled), 0);

        // constant input -> stall on second zero window, then recovery
        wait_pulse(0, n);
        chk("zero1 rate", int'(rate), 0);
        chk("zero1 stalled", int'(stalled), 0);
        wait_pulse(0, n);
        chk("zero2 rate", int'(rate), 0);
        chk("zero2 stalled", int'(stalled), 1);
        wait_pulse(1, n);
        chk("recover rate", int'(rate), 16);
        chk("recover stalled", int'(stalled), 0);

        // clear on the terminal-count cycle
        for (int i = 0; i < WIN - 1; i++) begin
            in_cnt = in_cnt + 8'd3;
            @(negedge clk);
        end
        clear = 1'b1;
        in_cnt = in_cnt + 8'd3;
        @(negedge clk);
        clear = 1'b0;
        chk("clear tc no pulse", int'(rate_valid), 0);
        chk("clear tc rate", int'(rate), 0);
        wait_pulse(3, n);
        chk("after clear latency", n, WIN);
        chk("after clear rate", int'(rate), 48);

        // rate sequence 48, 16, 80 for extreme tracking
        wait_pulse(1, n);
        chk("seq rate 16", int'(rate), 16);
        wait_pulse(5, n);
        chk("seq rate 80", int'(rate), 80);
`ifdef PERIOD_RATE_MINMAX_EN
        chk("seq min_rate", int'(min_rate), 16);
        chk("seq max_rate", int'(max_rate), 80);
`endif
        enable = 1'b0;
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        chk("clear idle rate", int'(rate), 0);
`ifdef PERIOD_RATE_MINMAX_EN
        chk("clear min_rate", int'(min_rate), 255);
        chk("clear max_rate", int'(max_rate), 0);
`endif

        // reset wins over clear and enable
        enable = 1'b1;
        repeat (4) begin
            in_cnt = in_cnt + 8'd7;
            @(negedge clk);
        end
        reset = 1'b1; clear = 1'b1;
        @(negedge clk);
        chk("reset prio rate_valid", int'(rate_valid), 0);
        chk("reset prio rate", int'(rate), 0);
        reset = 1'b0; clear = 1'b0; enable = 1'b0;
        repeat (3) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

endmodule

// File: doc/period_rate_meter.md
PERIOD_RATE_METER -- requirements
Module: period_rate_meter

Interface
REQ-001 SHALL have parameter BUS_SIZE, default 8: width of the sampled counter bus and of the rate result.
REQ-002 SHALL have parameter WINDOW_CYCLES, default 1024: measurement window length in clk cycles, legal range 2..65536.
REQ-003 SHALL have parameter STALL_WINDOWS, default 2: number of consecutive zero-delta windows before stalled asserts, legal range 1..15.
REQ-004 SHALL have port clk  in  1  sole clock; same domain as the destination side of the upstream period bus synchronizer.
REQ-005 SHALL have port reset  in  1  reset, synchronous, active-high.
REQ-006 SHALL have port in_cnt  in  BUS_SIZE  free-running counter snapshot, already synchronized to clk.
REQ-007 SHALL have port enable  in  1  measurement enable, level-sensitive.
REQ-008 SHALL have port clear  in  1  single-cycle request to restart the measurement and statistics.
REQ-009 SHALL have port rate  out  BUS_SIZE  counter delta over the last completed window.
REQ-010 SHALL have port rate_valid  out  1  one-cycle pulse marking a new rate value.
REQ-011 SHALL have port stalled  out  1  in_cnt has not advanced for STALL_WINDOWS consecutive windows.
REQ-012 SHALL have ports min_rate and max_rate  out  BUS_SIZE  extreme rates since reset or clear; present only under the macro in REQ-030.

Function
REQ-013 SHALL implement a two-state FSM: IDLE and MEASURE.
REQ-014 In IDLE with enable=1, SHALL capture prev<=in_cnt, set win_cnt<=0, and go to MEASURE.
REQ-015 In MEASURE, SHALL increment win_cnt every cycle while win_cnt < WINDOW_CYCLES-1.
REQ-016 At the edge where win_cnt==WINDOW_CYCLES-1, SHALL do all of: rate<=in_cnt-prev (modulo 2^BUS_SIZE); rate_valid<=1; prev<=in_cnt; win_cnt<=0.
REQ-017 SHALL deliver the first rate_valid exactly WINDOW_CYCLES cycles after the prev capture, and subsequent pulses every WINDOW_CYCLES cycles.
REQ-018 SHALL let the delta subtraction wrap naturally; at most one upstream counter wrap per window is representable, and detection of more is out of scope.
REQ-019 SHALL hold rate_valid low in every cycle other than those defined in REQ-016.
REQ-020 SHALL hold rate at its last value between pulses.
REQ-021 On enable=0 in MEASURE, SHALL go to IDLE, set win_cnt<=0, discard the partial window, produce no pulse, and hold rate and stalled.
REQ-022 On clear=1, SHALL set rate<=0, stalled<=0, zero-window count<=0, and statistics to reset values; if enable=1 it SHALL recapture prev<=in_cnt and set win_cnt<=0 in MEASURE, otherwise it SHALL go to IDLE.
REQ-023 When clear and the terminal count of REQ-016 coincide, clear SHALL win and no rate_valid SHALL occur.
REQ-024 SHALL saturate the zero-window counter at STALL_WINDOWS; a zero delta increments it and a nonzero delta sets it to 0.
REQ-025 SHALL assert stalled (registered, same edge as rate_valid) while the zero-window count equals STALL_WINDOWS, and deassert it on the first nonzero delta.

Reset
REQ-026 On reset, SHALL set the state to IDLE, win_cnt=0, prev=0, rate=0, rate_valid=0, stalled=0, and zero-window count=0.
REQ-027 Under the macro, reset SHALL additionally set min_rate to all ones and max_rate to 0.
REQ-028 Reset SHALL take priority over clear and enable.

Configuration
REQ-029 SHALL compile min/max tracking only when the macro PERIOD_RATE_MINMAX_EN is defined.
REQ-030 With PERIOD_RATE_MINMAX_EN defined, on each rate_valid edge SHALL set min_rate<=min(min_rate,delta) and max_rate<=max(max_rate,delta), using the new delta.
REQ-031 Without PERIOD_RATE_MINMAX_EN, the min_rate and max_rate ports and their registers SHALL be absent, and all other behaviour SHALL be unchanged.

Structure
REQ-032 SHALL place the FSM state enum type and the default window constant in the shared package period_rate_pkg.
REQ-033 SHALL place the window counter (count, terminal-count flag, synchronous restart) in the sub-module period_rate_window_cnt, width $clog2(WINDOW_CYCLES).

Verification (BUS_SIZE=8, WINDOW_CYCLES=16, STALL_WINDOWS=2)
REQ-034 SHALL cover: in_cnt +3 per cycle, enable held -> rate_valid every 16 cycles, rate=48, stalled=0.
REQ-035 SHALL cover: prev=0xF0, in_cnt=0x20 at terminal count -> rate=0x30.
REQ-036 SHALL cover: in_cnt constant -> rate=0 twice, stalled=1 on the 2nd pulse; next window with +1 per cycle -> rate=16, stalled=0.
REQ-037 SHALL cover: clear asserted on the terminal-count cycle -> no pulse, rate=0, next pulse 16 cycles later.
REQ-038 SHALL cover: enable dropped at win_cnt=7, re-raised 5 cycles later -> no pulse for the partial window, first pulse 16 cycles after re-capture.
REQ-039 SHALL cover, with PERIOD_RATE_MINMAX_EN: rate sequence 48, 16, 80 -> min_rate=16, max_rate=80; clear -> min_rate=0xFF, max_rate=0.
